// File: rtl/spm_offset_move_scheduler_if.sv
// Requester / adjuster bundle of the offset move scheduler: move requests with
// packed per-requester targets, adjuster monitor readback, and target/status outputs.
interface spm_offset_move_scheduler_if #(
  parameter int NREQ = 3
);
  logic [NREQ-1:0]      req;
  logic [NREQ*32-1:0]   req_x0;
  logic [NREQ*32-1:0]   req_y0;
  logic [NREQ*32-1:0]   req_z0;
  logic [NREQ*32-1:0]   req_xy_step;
  logic [NREQ*32-1:0]   req_z_step;
  logic                 abort;
  logic signed [31:0]   x0_mon;
  logic signed [31:0]   y0_mon;
  logic signed [31:0]   z0_mon;
  logic signed [31:0]   x0;
  logic signed [31:0]   y0;
  logic signed [31:0]   z0;
  logic [31:0]          xy_step;
  logic [31:0]          z_step;
  logic [NREQ-1:0]      grant;
  logic [NREQ-1:0]      done;
  logic [1:0]           err;
  logic                 busy;

  modport master (
    output req, req_x0, req_y0, req_z0, req_xy_step, req_z_step, abort,
    output x0_mon, y0_mon, z0_mon,
    input  x0, y0, z0, xy_step, z_step, grant, done, err, busy
  );

  modport slave (
    input  req, req_x0, req_y0, req_z0, req_xy_step, req_z_step, abort,
    input  x0_mon, y0_mon, z0_mon,
    output x0, y0, z0, xy_step, z_step, grant, done, err, busy
  );
endinterface

// File: rtl/spm_offset_move_scheduler.sv
// Round-robin scheduler of absolute offset moves onto the single SPM offset adjuster.
// Optional MOVING/SETTLE watchdog compiled in with `define SPM_MOVE_TIMEOUT_EN.
module spm_offset_move_scheduler #(
  parameter int          NREQ           = 3,
  parameter int          SETTLE_CYCLES  = 128,
`ifdef SPM_MOVE_TIMEOUT_EN
  parameter int          TIMEOUT_CYCLES = 1 << 27,
`endif
  parameter logic [31:0] DEF_XY_STEP    = 32'd32,
  parameter logic [31:0] DEF_Z_STEP     = 32'd1
) (
  input  logic                    a_clk,
  input  logic                    a_resetn,
  spm_offset_move_scheduler_if.slave bus
);

  localparam int          IW          = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [31:0] SETTLE_LOAD = 32'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MOVING,
    S_SETTLE,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [IW-1:0]      last_q, last_d;
  logic [NREQ-1:0]    grant_q, grant_d;
  logic [NREQ-1:0]    done_q, done_d;
  logic [1:0]         err_q, err_d;
  logic               busy_q, busy_d;
  logic signed [31:0] x0_q, x0_d, y0_q, y0_d, z0_q, z0_d;
  logic [31:0]        xy_step_q, xy_step_d, z_step_q, z_step_d;
  logic [31:0]        settle_q, settle_d;

  logic [IW-1:0]      win_idx, cand;
  logic               win_found;
  logic               arrived;
  logic               in_move;
  logic               timeout;
  logic [IW+4:0]      base;

  assign arrived = (bus.x0_mon == x0_q) && (bus.y0_mon == y0_q) && (bus.z0_mon == z0_q);
  assign in_move = (state_q == S_LOAD) || (state_q == S_MOVING) || (state_q == S_SETTLE);
  assign base    = {last_q, 5'd0};

`ifdef SPM_MOVE_TIMEOUT_EN
  logic [31:0] tmo_q, tmo_d;

  // Watchdog restarts in LOAD so MOVING cycle 1 sees a count of zero.
  always_comb begin
    tmo_d = tmo_q;
    if (state_q == S_LOAD) begin
      tmo_d = '0;
    end else if ((state_q == S_MOVING) || (state_q == S_SETTLE)) begin
      tmo_d = tmo_q + 32'd1;
    end
  end

  assign timeout = ((state_q == S_MOVING) || (state_q == S_SETTLE)) &&
                   (tmo_q == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge a_clk or negedge a_resetn) begin
    if (!a_resetn) tmo_q <= '0;
    else           tmo_q <= tmo_d;
  end
`else
  assign timeout = 1'b0;
`endif

  // Round-robin search starts one past the last granted index.
  always_comb begin
    win_found = 1'b0;
    win_idx   = last_q;
    cand      = last_q;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(last_q) + k) % NREQ);
      if (!win_found && bus.req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    grant_d   = grant_q;
    done_d    = '0;
    err_d     = 2'b00;
    x0_d      = x0_q;
    y0_d      = y0_q;
    z0_d      = z0_q;
    xy_step_d = xy_step_q;
    z_step_d  = z_step_q;
    settle_d  = settle_q;

    unique case (state_q)
      S_IDLE: begin
        if (win_found && !bus.abort) begin
          last_d           = win_idx;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          state_d          = S_LOAD;
        end
      end
      S_LOAD: begin
        x0_d      = $signed(bus.req_x0[base +: 32]);
        y0_d      = $signed(bus.req_y0[base +: 32]);
        z0_d      = $signed(bus.req_z0[base +: 32]);
        xy_step_d = bus.req_xy_step[base +: 32];
        z_step_d  = bus.req_z_step[base +: 32];
        state_d   = S_MOVING;
      end
      S_MOVING: begin
        if (arrived) begin
          settle_d = SETTLE_LOAD;
          state_d  = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (!arrived) begin
          state_d = S_MOVING;
        end else if (settle_q == '0) begin
          done_d  = grant_q;
          state_d = S_DONE;
        end else begin
          settle_d = settle_q - 32'd1;
        end
      end
      S_DONE: begin
        grant_d = '0;
        state_d = S_IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = S_IDLE;
      end
    endcase

    // Abort or watchdog parks the adjuster where it currently is.
    if (in_move && (bus.abort || timeout)) begin
      x0_d    = bus.x0_mon;
      y0_d    = bus.y0_mon;
      z0_d    = bus.z0_mon;
      err_d   = bus.abort ? 2'b01 : 2'b10;
      done_d  = '0;
      grant_d = '0;
      state_d = S_IDLE;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge a_clk or negedge a_resetn) begin
    if (!a_resetn) begin
      state_q   <= S_IDLE;
      last_q    <= IW'(NREQ - 1);
      grant_q   <= '0;
      done_q    <= '0;
      err_q     <= 2'b00;
      busy_q    <= 1'b0;
      x0_q      <= '0;
      y0_q      <= '0;
      z0_q      <= '0;
      xy_step_q <= DEF_XY_STEP;
      z_step_q  <= DEF_Z_STEP;
      settle_q  <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      x0_q      <= x0_d;
      y0_q      <= y0_d;
      z0_q      <= z0_d;
      xy_step_q <= xy_step_d;
      z_step_q  <= z_step_d;
      settle_q  <= settle_d;
    end
  end

  assign bus.x0      = x0_q;
  assign bus.y0      = y0_q;
  assign bus.z0      = z0_q;
  assign bus.xy_step = xy_step_q;
  assign bus.z_step  = z_step_q;
  assign bus.grant   = grant_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_spm_offset_move_scheduler.sv
// Directed + randomized bench for spm_offset_move_scheduler with an adjuster
// plant (ramp / track / manual monitors) and a round-robin reference model.
module tb_spm_offset_move_scheduler;
  localparam int NREQ   = 3;
  localparam int SETTLE = 8;
`ifdef SPM_MOVE_TIMEOUT_EN
  localparam int TMO    = 1000;
`endif

  logic a_clk    = 1'b0;
  logic a_resetn = 1'b0;

  spm_offset_move_scheduler_if #(.NREQ(NREQ)) bus ();

  spm_offset_move_scheduler #(
    .NREQ          (NREQ),
    .SETTLE_CYCLES (SETTLE),
`ifdef SPM_MOVE_TIMEOUT_EN
    .TIMEOUT_CYCLES(TMO),
`endif
    .DEF_XY_STEP   (32'd32),
    .DEF_Z_STEP    (32'd1)
  ) dut (
    .a_clk   (a_clk),
    .a_resetn(a_resetn),
    .bus     (bus.slave)
  );

  always #5 a_clk = ~a_clk;

  int cyc = 0;
  always @(posedge a_clk) cyc <= cyc + 1;

  // Plant: 0 = monitors from man_*, 1 = ramp 32 per 64 cycles, 2 = instantly on target.
  int mode = 0;
  logic signed [31:0] man_x = 0, man_y = 0, man_z = 0;
  logic signed [31:0] rx = 0, ry = 0, rz = 0;
  int ramp_t = 0;
  int last_chg = 0;
  int done_cnt = 0;

  function automatic logic signed [31:0] toward(input logic signed [31:0] cur,
                                                input logic signed [31:0] tgt);
    if (cur < tgt) return (tgt - cur > 32) ? cur + 32 : tgt;
    if (cur > tgt) return (cur - tgt > 32) ? cur - 32 : tgt;
    return cur;
  endfunction

  always @(posedge a_clk) begin
    ramp_t <= ramp_t + 1;
    if (mode == 1 && (ramp_t % 64) == 63) begin
      if (toward(rx, bus.x0) != rx || toward(ry, bus.y0) != ry || toward(rz, bus.z0) != rz)
        last_chg <= cyc + 1;
      rx <= toward(rx, bus.x0);
      ry <= toward(ry, bus.y0);
      rz <= toward(rz, bus.z0);
    end
  end

  always @(negedge a_clk) if (|bus.done) done_cnt <= done_cnt + 1;

  assign bus.x0_mon = (mode == 1) ? rx : (mode == 2) ? bus.x0 : man_x;
  assign bus.y0_mon = (mode == 1) ? ry : (mode == 2) ? bus.y0 : man_y;
  assign bus.z0_mon = (mode == 1) ? rz : (mode == 2) ? bus.z0 : man_z;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  logic signed [31:0] tx [NREQ];
  logic signed [31:0] ty [NREQ];
  logic signed [31:0] tz [NREQ];
  logic [31:0]        txs[NREQ];
  logic [31:0]        tzs[NREQ];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge a_clk);
    #1;
  endtask

  // which: 0 grant!=0, 1 done!=0, 2 err!=0
  task automatic wait_until(input int which, input int limit, output bit hit);
    hit = 1'b0;
    for (int i = 0; i < limit && !hit; i++) begin
      step(1);
      case (which)
        0:       hit = (bus.grant != '0);
        1:       hit = (bus.done != '0);
        default: hit = (bus.err != 2'b00);
      endcase
    end
    if (!hit) begin
      n_total++;
      n_fail++;
      $error("FAIL wait%0d observed=timeout expected=event within %0d cycles", which, limit);
    end
  endtask

  task automatic load_slices();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_x0[i*32 +: 32]      = tx[i];
      bus.req_y0[i*32 +: 32]      = ty[i];
      bus.req_z0[i*32 +: 32]      = tz[i];
      bus.req_xy_step[i*32 +: 32] = txs[i];
      bus.req_z_step[i*32 +: 32]  = tzs[i];
    end
  endtask

  task automatic rand_targets();
    for (int i = 0; i < NREQ; i++) begin
      tx[i]  = $urandom;
      ty[i]  = $urandom;
      tz[i]  = $urandom;
      txs[i] = $urandom;
      tzs[i] = $urandom;
    end
    load_slices();
  endtask

  // Reference arbitration: first requester after the last grant, wrapping.
  function automatic int rr_pick(input logic [NREQ-1:0] m, input int last);
    for (int k = 1; k <= NREQ; k++)
      if (m[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_grant"}, 32'(bus.grant), 32'd0);
    chk({tag, "_busy"},  32'(bus.busy), 32'd0);
    chk({tag, "_done"},  32'(bus.done), 32'd0);
    chk({tag, "_err"},   32'(bus.err), 32'd0);
    chk({tag, "_x0"},    bus.x0, 32'd0);
    chk({tag, "_y0"},    bus.y0, 32'd0);
    chk({tag, "_z0"},    bus.z0, 32'd0);
    chk({tag, "_xystep"}, bus.xy_step, 32'd32);
    chk({tag, "_zstep"}, bus.z_step, 32'd1);
  endtask

  initial begin
    bit hit;
    int t0, g, exp_w, model_last, dc, gl_end;
    logic [NREQ-1:0] mask;

    bus.req = '0;
    bus.abort = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      tx[i] = 0; ty[i] = 0; tz[i] = 0; txs[i] = 0; tzs[i] = 0;
    end
    load_slices();
    model_last = NREQ - 1;

    a_resetn = 1'b0;
    step(2);
    chk_reset_vals("rst");
    a_resetn = 1'b1;
    step(1);

    // Ramped move for requester 0, owner drops req mid-move.
    mode = 1;
    tx[0] = 32'h1000; ty[0] = -32'sh800; tz[0] = 32'h40; txs[0] = 32; tzs[0] = 1;
    load_slices();
    bus.req = 3'b001;
    step(1);
    chk("s1_grant", 32'(bus.grant), 32'b001);
    chk("s1_busy", 32'(bus.busy), 32'd1);
    step(1);
    chk("s1_x0", bus.x0, 32'h1000);
    chk("s1_y0", bus.y0, 32'hFFFF_F800);
    chk("s1_z0", bus.z0, 32'h40);
    chk("s1_xystep", bus.xy_step, 32'd32);
    chk("s1_zstep", bus.z_step, 32'd1);
    bus.req = '0;
    model_last = 0;
    wait_until(1, 20000, hit);
    if (hit) begin
      chk("s1_done", 32'(bus.done), 32'b001);
      chk("s1_done_lat", 32'(cyc - last_chg), 32'(SETTLE + 1));
    end
    step(1);
    chk("s1_idle_grant", 32'(bus.grant), 32'd0);
    chk("s1_idle_busy", 32'(bus.busy), 32'd0);
    chk("s1_idle_done", 32'(bus.done), 32'd0);
    chk("s1_hold_x0", bus.x0, 32'h1000);

    // Round robin: four rounds with all held, then random masks with noise.
    mode = 2;
    for (int r = 0; r < 10; r++) begin
      mask = (r < 4) ? 3'b111 : 3'(($urandom % 7) + 1);
      rand_targets();
      bus.req = mask;
      exp_w = rr_pick(mask, model_last);
      t0 = cyc;
      wait_until(0, 10, hit);
      if (hit) begin
        chk("rr_grant", 32'(bus.grant), 32'(1 << exp_w));
        chk("rr_grant_lat", 32'(cyc - t0), 32'd1);
      end
      model_last = exp_w;
      step(1);
      chk("rr_x0", bus.x0, tx[exp_w]);
      chk("rr_z0", bus.z0, tz[exp_w]);
      chk("rr_xystep", bus.xy_step, txs[exp_w]);
      if (r >= 4) bus.req = 3'($urandom);
      wait_until(1, SETTLE + 10, hit);
      if (hit) begin
        chk("rr_done", 32'(bus.done), 32'(1 << exp_w));
        chk("rr_done_lat", 32'(cyc - t0), 32'(SETTLE + 3));
      end
      step(1);
      chk("rr_idle_grant", 32'(bus.grant), 32'd0);
      chk("rr_idle_busy", 32'(bus.busy), 32'd0);
    end
    bus.req = '0;

    // Abort while MOVING freezes targets at the monitors.
    mode = 0;
    rand_targets();
    tx[1] = tx[1] | 32'h1;
    load_slices();
    man_x = 32'h500; man_y = $urandom; man_z = $urandom;
    bus.req = 3'b010;
    exp_w = rr_pick(3'b010, model_last);
    wait_until(0, 10, hit);
    if (hit) chk("ab_grant", 32'(bus.grant), 32'b010);
    model_last = exp_w;
    step(1);
    chk("ab_x0_pre", bus.x0, tx[1]);
    dc = done_cnt;
    bus.abort = 1'b1;
    step(1);
    chk("ab_x0", bus.x0, 32'h500);
    chk("ab_y0", bus.y0, man_y);
    chk("ab_z0", bus.z0, man_z);
    chk("ab_err", 32'(bus.err), 32'b01);
    chk("ab_done", 32'(bus.done), 32'd0);
    chk("ab_grant_clr", 32'(bus.grant), 32'd0);
    chk("ab_busy", 32'(bus.busy), 32'd0);
    step(1);
    chk("ab_err_pulse", 32'(bus.err), 32'b00);
    step(2);
    chk("ab_hold_grant", 32'(bus.grant), 32'd0);
    chk("ab_no_done", 32'(done_cnt), 32'(dc));
    bus.abort = 1'b0;
    step(1);
    chk("ab_regrant", 32'(bus.grant), 32'(1 << rr_pick(3'b010, model_last)));
    man_x = tx[1]; man_y = ty[1]; man_z = tz[1];
    bus.req = '0;
    wait_until(1, SETTLE + 10, hit);
    if (hit) chk("ab_done2", 32'(bus.done), 32'b010);
    step(1);

    // Monitor glitch during SETTLE forces a full re-settle.
    rand_targets();
    mask = 3'b100;
    exp_w = rr_pick(mask, model_last);
    man_x = tx[exp_w]; man_y = ty[exp_w]; man_z = tz[exp_w];
    bus.req = mask;
    wait_until(0, 10, hit);
    g = cyc;
    if (hit) chk("gl_grant", 32'(bus.grant), 32'(1 << exp_w));
    model_last = exp_w;
    bus.req = '0;
    step(3);
    man_x = tx[exp_w] + 1;
    step(1);
    man_x = tx[exp_w];
    gl_end = cyc;
    wait_until(1, 3 * SETTLE + 10, hit);
    if (hit) begin
      chk("gl_done", 32'(bus.done), 32'(1 << exp_w));
      chk("gl_done_lat", 32'(cyc - gl_end), 32'(SETTLE + 1));
      chk("gl_extra", 32'(cyc - g), 32'(SETTLE + 5));
    end
    chk("gl_x0", bus.x0, tx[exp_w]);
    step(1);

`ifdef SPM_MOVE_TIMEOUT_EN
    // Frozen monitors: watchdog fires on MOVING cycle TMO.
    rand_targets();
    man_x = tx[0] ^ 32'h1; man_y = ty[0]; man_z = tz[0];
    mask = 3'b001;
    exp_w = rr_pick(mask, model_last);
    bus.req = mask;
    wait_until(0, 10, hit);
    g = cyc;
    model_last = exp_w;
    bus.req = '0;
    dc = done_cnt;
    wait_until(2, TMO + 20, hit);
    if (hit) begin
      chk("to_err", 32'(bus.err), 32'b10);
      chk("to_lat", 32'(cyc - g), 32'(TMO + 1));
      chk("to_x0", bus.x0, man_x);
      chk("to_grant", 32'(bus.grant), 32'd0);
    end
    chk("to_no_done", 32'(done_cnt), 32'(dc));
    step(1);
`endif

    // Asynchronous reset in SETTLE, then req[0] wins first.
    mode = 2;
    rand_targets();
    bus.req = 3'b110;
    wait_until(0, 10, hit);
    step(4);
    a_resetn = 1'b0;
    #1;
    chk_reset_vals("mrst");
    #2;
    a_resetn = 1'b1;
    bus.req = 3'b111;
    step(1);
    chk("mrst_grant", 32'(bus.grant), 32'b001);
    step(1);
    chk("mrst_x0", bus.x0, tx[0]);
    bus.req = '0;
    wait_until(1, SETTLE + 10, hit);
    if (hit) chk("mrst_done", 32'(bus.done), 32'b001);
    step(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
